// File: rtl/fifo_ptr_status_ctrl.sv
// FIFO pointer and status controller.
// Owns the write/read pointers (ADDR_WIDTH+1 bits, MSB is the wrap bit) and
// derives occupancy count, full/empty, almost-full/almost-empty and sticky
// overflow/underflow flags. All status is registered from the next-state
// pointers so flags move on the same edge as the pointers.
module fifo_ptr_status_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_ena,
  input  logic                  read_ena,
  input  logic                  clear,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   write_addr,
  output logic [ADDR_WIDTH:0]   read_addr,
  output logic                  wr_accept,
  output logic                  rd_accept,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

  // Reject threshold settings that could never (or always) assert.
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_ptr_status_ctrl: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_ptr_status_ctrl: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [PW-1:0] wptr_nxt;
  logic [PW-1:0] rptr_nxt;
  logic [PW-1:0] count_nxt;
  logic          full_nxt;
  logic          empty_nxt;
  logic          ovf_set;
  logic          unf_set;

  // Accept strobes: a flush cycle swallows every request.
  assign wr_accept = write_ena & ~full  & ~clear;
  assign rd_accept = read_ena  & ~empty & ~clear;

  // Errors are only raised by requests refused for lack of room/data,
  // never by requests dropped because of a flush.
  assign ovf_set = write_ena & full  & ~clear;
  assign unf_set = read_ena  & empty & ~clear;

  // Next-state pointers and the status derived from them.
  always_comb begin
    wptr_nxt  = clear ? '0 : write_addr + PW'(wr_accept);
    rptr_nxt  = clear ? '0 : read_addr  + PW'(rd_accept);
    count_nxt = wptr_nxt - rptr_nxt;
    empty_nxt = (wptr_nxt == rptr_nxt);
    full_nxt  = (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
  end

  // Pointer, count and flag registers; error set takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_addr   <= '0;
      read_addr    <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      write_addr   <= wptr_nxt;
      read_addr    <= rptr_nxt;
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= (count_nxt >= AFULL_T);
      almost_empty <= (count_nxt <= AEMPTY_T);
      overflow     <= ovf_set | (overflow  & ~err_clr);
      underflow    <= unf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_status_ctrl.sv
// Scoreboard bench for fifo_ptr_status_ctrl (ADDR_WIDTH=4, AF=12, AE=2).
// The stimulus process drives one request per cycle on the falling edge and
// queues the hand-derived expected accepts and post-edge state; the monitor
// pops each entry and compares against the DUT.
module tb_fifo_ptr_status_ctrl;

  logic       clk;
  logic       rst_n;
  logic       write_ena, read_ena, clear, err_clr;
  logic [4:0] write_addr, read_addr, count;
  logic       wr_accept, rd_accept;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_ptr_status_ctrl #(
    .ADDR_WIDTH   (4),
    .AFULL_THRESH (12),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_ena   (write_ena),
    .read_ena    (read_ena),
    .clear       (clear),
    .err_clr     (err_clr),
    .write_addr  (write_addr),
    .read_addr   (read_addr),
    .wr_accept   (wr_accept),
    .rd_accept   (rd_accept),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string    tag;
    bit       is_rst;
    bit       wacc;
    bit       racc;
    int       wa;
    int       ra;
    int       cnt;
    bit       f_full;
    bit       f_empty;
    bit       f_af;
    bit       f_ae;
    bit       ov;
    bit       un;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt  = 0;
  int   pass_cnt   = 0;
  int   issued_cnt = 0;
  int   done_cnt   = 0;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Expected status for a given occupancy with DEPTH=16, AF=12, AE=2.
  task automatic push_exp(input string tag, input bit is_rst, input bit wacc, input bit racc,
                          input int wa, input int ra, input int cnt, input bit ov, input bit un);
    exp_t e;
    e.tag     = tag;
    e.is_rst  = is_rst;
    e.wacc    = wacc;
    e.racc    = racc;
    e.wa      = wa;
    e.ra      = ra;
    e.cnt     = cnt;
    e.f_full  = (cnt == 16);
    e.f_empty = (cnt == 0);
    e.f_af    = (cnt >= 12);
    e.f_ae    = (cnt <= 2);
    e.ov      = ov;
    e.un      = un;
    exp_q.push_back(e);
    issued_cnt++;
  endtask

  task automatic step(input string tag, input bit we, input bit re, input bit clr, input bit ec,
                      input bit ewacc, input bit eracc, input int ewa, input int era,
                      input int ecnt, input bit eov, input bit eun);
    @(negedge clk);
    rst_n     = 1'b1;
    write_ena = we;
    read_ena  = re;
    clear     = clr;
    err_clr   = ec;
    push_exp(tag, 1'b0, ewacc, eracc, ewa, era, ecnt, eov, eun);
  endtask

  // Assert reset between clock edges; the check happens before the next rising edge.
  task automatic rst_item(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    write_ena = 1'b0;
    read_ena  = 1'b0;
    clear     = 1'b0;
    err_clr   = 1'b0;
    push_exp(tag, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic cmp_state(input exp_t e, input bit a_w, input bit a_r);
    chk({e.tag, ".wr_accept"},    int'(a_w),          int'(e.wacc));
    chk({e.tag, ".rd_accept"},    int'(a_r),          int'(e.racc));
    chk({e.tag, ".write_addr"},   int'(write_addr),   e.wa);
    chk({e.tag, ".read_addr"},    int'(read_addr),    e.ra);
    chk({e.tag, ".count"},        int'(count),        e.cnt);
    chk({e.tag, ".full"},         int'(full),         int'(e.f_full));
    chk({e.tag, ".empty"},        int'(empty),        int'(e.f_empty));
    chk({e.tag, ".almost_full"},  int'(almost_full),  int'(e.f_af));
    chk({e.tag, ".almost_empty"}, int'(almost_empty), int'(e.f_ae));
    chk({e.tag, ".overflow"},     int'(overflow),     int'(e.ov));
    chk({e.tag, ".underflow"},    int'(underflow),    int'(e.un));
  endtask

  // Monitor: accepts sampled mid-cycle, registered state sampled 1 unit after the edge.
  initial begin
    exp_t e;
    bit   a_w, a_r;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        a_w = wr_accept;
        a_r = rd_accept;
        if (!e.is_rst) begin
          @(posedge clk);
          #1;
        end
        cmp_state(e, a_w, a_r);
        done_cnt++;
      end
    end
  end

  // Stimulus with hand-derived expectations.
  initial begin
    rst_n     = 1'b0;
    write_ena = 1'b0;
    read_ena  = 1'b0;
    clear     = 1'b0;
    err_clr   = 1'b0;

    rst_item("reset");

    // Fill 16: count 1..16, almost_full from 12, full after the 16th, wptr=5'b10000.
    for (int i = 0; i < 16; i++)
      step("fill", 1, 0, 0, 0, 1, 0, i + 1, 0, i + 1, 0, 0);

    // Write while full: refused, overflow sticky, err_clr clears it.
    step("ovf_write", 1, 0, 0, 0, 0, 0, 16, 0, 16, 1, 0);
    step("ovf_hold",  0, 0, 0, 0, 0, 0, 16, 0, 16, 1, 0);
    step("ovf_clr",   0, 0, 0, 1, 0, 0, 16, 0, 16, 0, 0);

    // Write+read while full: read accepted, write refused (overflow), full drops.
    step("full_wr_rd", 1, 1, 0, 0, 0, 1, 16, 1, 15, 1, 0);
    step("ovf_clr2",   0, 0, 0, 1, 0, 0, 16, 1, 15, 0, 0);

    // Drain to empty.
    for (int i = 0; i < 15; i++)
      step("drain", 0, 1, 0, 0, 0, 1, 16, i + 2, 14 - i, 0, 0);

    // Write+read while empty: write accepted, read refused (underflow).
    step("empty_wr_rd", 1, 1, 0, 0, 1, 0, 17, 16, 1, 0, 1);
    step("unf_clr",     0, 0, 0, 1, 0, 0, 17, 16, 1, 0, 0);

    // Bring occupancy to 8.
    for (int i = 0; i < 7; i++)
      step("to8", 1, 0, 0, 0, 1, 0, 18 + i, 16, 2 + i, 0, 0);

    // Steady write+read at count 8 for 40 cycles; pointers wrap past 31.
    for (int i = 0; i < 40; i++)
      step("steady", 1, 1, 0, 0, 1, 1, (25 + i) % 32, (17 + i) % 32, 8, 0, 0);

    // Up to 10, then flush with a write pending.
    step("to10a", 1, 0, 0, 0, 1, 0, 1, 24, 9, 0, 0);
    step("to10b", 1, 0, 0, 0, 1, 0, 2, 24, 10, 0, 0);
    step("clear_wr", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Underflow set beats err_clr; a flushed read raises nothing.
    step("unf_set",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("unf_set_wins", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("clear_rd",     0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a burst, then resume.
    for (int i = 0; i < 3; i++)
      step("burst", 1, 0, 0, 0, 1, 0, i + 1, 0, i + 1, 0, 0);
    rst_item("async_rst");
    step("post_rst_wr", 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);

    @(negedge clk);
    write_ena = 1'b0;
    read_ena  = 1'b0;
    clear     = 1'b0;
    err_clr   = 1'b0;

    for (int k = 0; k < 20 && done_cnt != issued_cnt; k++)
      @(negedge clk);
    chk("drain_scoreboard", done_cnt, issued_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
